// File: rtl/acc_cmd_endpoint.sv
// Accelerator-side command endpoint: buffers an execute-task command, runs the core, returns a finish message.
// Optional build macro ACC_CMD_EXEC_CYCLES_EN appends an EXEC cycle-count word to the finish message.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_IDLE    | waiting for command word0 (code, nargs)
// S_TID     | waiting for task-ID word
// S_ARGS    | storing argument words until tlast
// S_DRAIN   | discarding the rest of an unknown command until tlast
// S_EXEC    | start pulse on first cycle, then wait for acc_done
// S_FIN_HDR | driving finish word0 (code 0x03, ACC_ID)
// S_FIN_TID | driving finish word1 (task ID)
// S_FIN_CYC | driving EXEC cycle count (only with ACC_CMD_EXEC_CYCLES_EN)

module acc_cmd_endpoint #(
   parameter int ACC_ID   = 0,
   parameter int MAX_ACCS = 16,
   parameter int MAX_ARGS = 8
) (
   input  logic                        aclk,
   input  logic                        rst,
   input  logic                        cmdin_in_tvalid,
   output logic                        cmdin_in_tready,
   input  logic [63:0]                 cmdin_in_tdata,
   input  logic                        cmdin_in_tlast,
   output logic                        cmdout_out_tvalid,
   input  logic                        cmdout_out_tready,
   output logic [$clog2(MAX_ACCS)-1:0] cmdout_out_tid,
   output logic [63:0]                 cmdout_out_tdata,
   output logic                        acc_start,
   input  logic                        acc_done,
   output logic [63:0]                 acc_task_id,
   output logic [3:0]                  acc_nargs,
   output logic [MAX_ARGS*64-1:0]      acc_args,
   output logic                        err_bad_cmd,
   output logic                        err_overflow
);

   localparam int          TID_W        = $clog2(MAX_ACCS);
   localparam logic [7:0]  CMD_EXEC     = 8'h01;
   localparam logic [7:0]  CMD_FIN      = 8'h03;
   localparam logic [3:0]  MAX_N        = 4'(MAX_ARGS);
   localparam logic [63:0] FIN_HDR_WORD = {48'd0, 8'(ACC_ID), CMD_FIN};

`ifdef ACC_CMD_EXEC_CYCLES_EN
   typedef enum logic [2:0] {
      S_IDLE, S_TID, S_ARGS, S_DRAIN, S_EXEC, S_FIN_HDR, S_FIN_TID, S_FIN_CYC
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE, S_TID, S_ARGS, S_DRAIN, S_EXEC, S_FIN_HDR, S_FIN_TID
   } state_t;
`endif

   state_t                    state, state_nxt;
   logic [MAX_ARGS-1:0][63:0] args_q;
   logic [3:0]                arg_idx;
   logic                      cmdin_acc;
   logic                      is_exec;
   logic [3:0]                nargs_in;
   logic [3:0]                nargs_sat;

`ifdef ACC_CMD_EXEC_CYCLES_EN
   logic [63:0]               exec_cnt;
`endif

   assign cmdin_in_tready = (state == S_IDLE) || (state == S_TID) ||
                            (state == S_ARGS) || (state == S_DRAIN);
   assign cmdin_acc       = cmdin_in_tvalid && cmdin_in_tready;
   assign is_exec         = (cmdin_in_tdata[7:0] == CMD_EXEC);
   assign nargs_in        = cmdin_in_tdata[11:8];
   assign nargs_sat       = (nargs_in > MAX_N) ? MAX_N : nargs_in;
   assign cmdout_out_tid  = TID_W'(ACC_ID);
   assign acc_args        = args_q;

   always_comb begin
      state_nxt         = state;
      cmdout_out_tvalid = 1'b0;
      cmdout_out_tdata  = '0;
      case (state)
         S_IDLE: begin
            if (cmdin_acc && !cmdin_in_tlast)
               state_nxt = is_exec ? S_TID : S_DRAIN;
         end
         S_TID: begin
            if (cmdin_acc)
               state_nxt = cmdin_in_tlast ? S_EXEC : S_ARGS;
         end
         S_ARGS: begin
            if (cmdin_acc && cmdin_in_tlast)
               state_nxt = S_EXEC;
         end
         S_DRAIN: begin
            if (cmdin_acc && cmdin_in_tlast)
               state_nxt = S_IDLE;
         end
         S_EXEC: begin
            if (acc_done)
               state_nxt = S_FIN_HDR;
         end
         S_FIN_HDR: begin
            cmdout_out_tvalid = 1'b1;
            cmdout_out_tdata  = FIN_HDR_WORD;
            if (cmdout_out_tready)
               state_nxt = S_FIN_TID;
         end
         S_FIN_TID: begin
            cmdout_out_tvalid = 1'b1;
            cmdout_out_tdata  = acc_task_id;
            if (cmdout_out_tready)
`ifdef ACC_CMD_EXEC_CYCLES_EN
               state_nxt = S_FIN_CYC;
`else
               state_nxt = S_IDLE;
`endif
         end
`ifdef ACC_CMD_EXEC_CYCLES_EN
         S_FIN_CYC: begin
            cmdout_out_tvalid = 1'b1;
            cmdout_out_tdata  = exec_cnt;
            if (cmdout_out_tready)
               state_nxt = S_IDLE;
         end
`endif
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (rst) begin
         state        <= S_IDLE;
         acc_start    <= 1'b0;
         acc_task_id  <= '0;
         acc_nargs    <= '0;
         args_q       <= '0;
         arg_idx      <= '0;
         err_bad_cmd  <= 1'b0;
         err_overflow <= 1'b0;
      end else begin
         state     <= state_nxt;
         // registered so the pulse lands on the first EXEC cycle only
         acc_start <= (state_nxt == S_EXEC) && (state != S_EXEC);
         if (cmdin_acc) begin
            case (state)
               S_IDLE: begin
                  if (is_exec && !cmdin_in_tlast)
                     acc_nargs <= nargs_sat;
                  else
                     err_bad_cmd <= 1'b1;
               end
               S_TID: begin
                  acc_task_id <= cmdin_in_tdata;
                  arg_idx     <= '0;
               end
               S_ARGS: begin
                  // index saturates at MAX_N; beyond that every word is an overflow
                  if (arg_idx < MAX_N) begin
                     for (int i = 0; i < MAX_ARGS; i++)
                        if (arg_idx == 4'(i))
                           args_q[i] <= cmdin_in_tdata;
                     arg_idx <= arg_idx + 4'd1;
                  end else begin
                     err_overflow <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

`ifdef ACC_CMD_EXEC_CYCLES_EN
   always_ff @(posedge aclk) begin
      if (rst)
         exec_cnt <= '0;
      else if (acc_start)
         exec_cnt <= 64'd1;
      else if (state == S_EXEC)
         exec_cnt <= exec_cnt + 64'd1;
   end
`endif

endmodule

// File: tb/tb_acc_cmd_endpoint.sv
// Bench for acc_cmd_endpoint: random core/sink timing and random commands checked against a command-level model.
module tb_acc_cmd_endpoint;

   localparam int ACC_ID   = 5;
   localparam int MAX_ACCS = 16;
   localparam int MAX_ARGS = 8;

   logic                     aclk = 1'b0;
   logic                     rst;
   logic                     cmdin_in_tvalid;
   logic                     cmdin_in_tready;
   logic [63:0]              cmdin_in_tdata;
   logic                     cmdin_in_tlast;
   logic                     cmdout_out_tvalid;
   logic                     cmdout_out_tready;
   logic [3:0]               cmdout_out_tid;
   logic [63:0]              cmdout_out_tdata;
   logic                     acc_start;
   logic                     acc_done;
   logic [63:0]              acc_task_id;
   logic [3:0]               acc_nargs;
   logic [MAX_ARGS*64-1:0]   acc_args;
   logic                     err_bad_cmd;
   logic                     err_overflow;

   acc_cmd_endpoint #(.ACC_ID(ACC_ID), .MAX_ACCS(MAX_ACCS), .MAX_ARGS(MAX_ARGS)) dut (
      .aclk              (aclk),
      .rst               (rst),
      .cmdin_in_tvalid   (cmdin_in_tvalid),
      .cmdin_in_tready   (cmdin_in_tready),
      .cmdin_in_tdata    (cmdin_in_tdata),
      .cmdin_in_tlast    (cmdin_in_tlast),
      .cmdout_out_tvalid (cmdout_out_tvalid),
      .cmdout_out_tready (cmdout_out_tready),
      .cmdout_out_tid    (cmdout_out_tid),
      .cmdout_out_tdata  (cmdout_out_tdata),
      .acc_start         (acc_start),
      .acc_done          (acc_done),
      .acc_task_id       (acc_task_id),
      .acc_nargs         (acc_nargs),
      .acc_args          (acc_args),
      .err_bad_cmd       (err_bad_cmd),
      .err_overflow      (err_overflow)
   );

   always #5 aclk = ~aclk;

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;
   always @(posedge aclk) cyc <= cyc + 1;

   // command-level model
   logic [63:0] m_args [MAX_ARGS];
   logic [63:0] m_tid;
   logic [3:0]  m_nargs;
   bit          m_bad, m_ovf;
   logic [63:0] exp_out [$];
   logic [63:0] tx_words [$];
   int          pending_start = 0;
   int          exp_starts    = 0;
   int          seen_starts   = 0;
   int          exp_start_cyc = 0;
   int          done_cyc      = -10;
   bit          hold_ready    = 1'b0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic finish_run();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   endtask

   task automatic model_reset();
      for (int i = 0; i < MAX_ARGS; i++) m_args[i] = '0;
      m_tid   = '0;
      m_nargs = '0;
      m_bad   = 1'b0;
      m_ovf   = 1'b0;
   endtask

   // applied at the moment the tlast word is known to be accepted
   task automatic model_cmd();
      logic [63:0] w0;
      int          n;
      w0 = tx_words[0];
      if (w0[7:0] == 8'h01 && tx_words.size() > 1) begin
         n       = int'(w0[11:8]);
         m_nargs = 4'((n > MAX_ARGS) ? MAX_ARGS : n);
         m_tid   = tx_words[1];
         for (int i = 0; i < tx_words.size() - 2; i++) begin
            if (i < MAX_ARGS) m_args[i] = tx_words[i + 2];
            else              m_ovf = 1'b1;
         end
         pending_start++;
         exp_starts++;
         exp_start_cyc = cyc + 1;
         exp_out.push_back((64'(ACC_ID) << 8) | 64'h03);
         exp_out.push_back(m_tid);
      end else begin
         m_bad = 1'b1;
      end
   endtask

   task automatic mk_exec(input int nfield, input int nwords, input logic [63:0] tid);
      tx_words.delete();
      tx_words.push_back((64'(nfield) << 8) | 64'h01 | (64'($urandom) << 32));
      tx_words.push_back(tid);
      for (int i = 0; i < nwords; i++) tx_words.push_back({$urandom, $urandom});
   endtask

   task automatic mk_other(input logic [7:0] code, input int nwords);
      tx_words.delete();
      tx_words.push_back({$urandom, 16'($urandom), 8'($urandom), code});
      for (int i = 0; i < nwords; i++) tx_words.push_back({$urandom, $urandom});
   endtask

   task automatic send_cmd(input int n_send);
      for (int i = 0; i < n_send; i++) begin
         int gap;
         int t;
         gap = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 2));
         repeat (gap) begin
            @(negedge aclk);
            cmdin_in_tvalid = 1'b0;
         end
         @(negedge aclk);
         cmdin_in_tvalid = 1'b1;
         cmdin_in_tdata  = tx_words[i];
         cmdin_in_tlast  = (i == tx_words.size() - 1);
         t = 0;
         while (!cmdin_in_tready) begin
            t++;
            if (t > 400) begin
               check("cmdin_timeout", 64'(t), 64'd0);
               finish_run();
            end
            @(negedge aclk);
         end
         if (i == 0) check("fin_drained", 64'(exp_out.size()), 64'd0);
         if (cmdin_in_tlast) model_cmd();
         @(posedge aclk);
      end
      @(negedge aclk);
      cmdin_in_tvalid = 1'b0;
      cmdin_in_tlast  = 1'b0;
   endtask

   task automatic check_errs();
      check("err_bad_cmd", 64'(err_bad_cmd), 64'(m_bad));
      check("err_overflow", 64'(err_overflow), 64'(m_ovf));
   endtask

   task automatic run_cmd();
      send_cmd(tx_words.size());
      check_errs();
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while ((exp_out.size() != 0 || pending_start != 0) && t < 300) begin
         @(negedge aclk);
         t++;
      end
      check("drain_timeout", 64'(t < 300), 64'd1);
   endtask

   task automatic check_reset_vals();
      check("rst_tvalid", 64'(cmdout_out_tvalid), 64'd0);
      check("rst_start", 64'(acc_start), 64'd0);
      check("rst_tready", 64'(cmdin_in_tready), 64'd1);
      check("rst_tid", acc_task_id, 64'd0);
      check("rst_nargs", 64'(acc_nargs), 64'd0);
      check("rst_bad", 64'(err_bad_cmd), 64'd0);
      check("rst_ovf", 64'(err_overflow), 64'd0);
      for (int i = 0; i < MAX_ARGS; i++) check($sformatf("rst_arg%0d", i), acc_args[i*64 +: 64], 64'd0);
   endtask

   // core model: random completion delay, 0 means done alongside start
   initial begin
      int done_cnt;
      int d;
      done_cnt = 0;
      acc_done = 1'b0;
      forever begin
         @(negedge aclk);
         acc_done = 1'b0;
         if (done_cnt > 0) begin
            done_cnt--;
            if (done_cnt == 0) begin
               acc_done = 1'b1;
               done_cyc = cyc;
            end
         end
         if (acc_start) begin
            seen_starts++;
            check("start_expected", 64'(pending_start > 0), 64'd1);
            check("start_latency", 64'(cyc), 64'(exp_start_cyc));
            if (pending_start > 0) pending_start--;
            check("acc_task_id", acc_task_id, m_tid);
            check("acc_nargs", 64'(acc_nargs), 64'(m_nargs));
            for (int i = 0; i < MAX_ARGS; i++) check($sformatf("acc_arg%0d", i), acc_args[i*64 +: 64], m_args[i]);
            d = int'($urandom_range(0, 4));
            if (d == 0) begin
               acc_done = 1'b1;
               done_cyc = cyc;
            end else begin
               done_cnt = d;
            end
         end
      end
   end

   // finish-message sink with random back-pressure
   initial begin
      logic        prev_v, prev_r;
      logic [63:0] prev_d;
      prev_v = 1'b0;
      prev_r = 1'b0;
      prev_d = '0;
      cmdout_out_tready = 1'b0;
      forever begin
         @(negedge aclk);
         cmdout_out_tready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
         if (cmdout_out_tvalid && !prev_v) check("fin_latency", 64'(cyc), 64'(done_cyc + 1));
         if (prev_v && !prev_r) begin
            check("out_hold_valid", 64'(cmdout_out_tvalid), 64'd1);
            check("out_hold_data", cmdout_out_tdata, prev_d);
         end
         if (cmdout_out_tvalid) check("cmdin_blocked", 64'(cmdin_in_tready), 64'd0);
         if (cmdout_out_tvalid && cmdout_out_tready) begin
            check("out_tid", 64'(cmdout_out_tid), 64'(ACC_ID));
            if (exp_out.size() == 0) check("out_unexpected", cmdout_out_tdata, 64'd0 - 64'd1);
            else                     check("out_word", cmdout_out_tdata, exp_out.pop_front());
         end
         prev_v = cmdout_out_tvalid;
         prev_r = cmdout_out_tready;
         prev_d = cmdout_out_tdata;
      end
   end

   initial begin
      #500000;
      check("watchdog", 64'd1, 64'd0);
      finish_run();
   end

   initial begin
      int kind;
      rst             = 1'b1;
      cmdin_in_tvalid = 1'b0;
      cmdin_in_tdata  = '0;
      cmdin_in_tlast  = 1'b0;
      model_reset();
      repeat (3) @(negedge aclk);
      rst = 1'b0;
      check_reset_vals();

      // two-argument command with fixed values
      tx_words.delete();
      tx_words.push_back(64'h0000_0201);
      tx_words.push_back(64'hABCD);
      tx_words.push_back(64'h11);
      tx_words.push_back(64'h22);
      run_cmd();
      wait_idle();

      // zero-argument command
      tx_words.delete();
      tx_words.push_back(64'h01);
      tx_words.push_back(64'h5);
      run_cmd();
      wait_idle();

      // argument overflow: nargs=10 with 10 words
      mk_exec(10, 10, 64'h1234_5678_9ABC_DEF0);
      run_cmd();
      wait_idle();

      // unknown code with trailing words, then a good command
      mk_other(8'h07, 3);
      run_cmd();
      mk_exec(3, 3, 64'h77);
      run_cmd();
      wait_idle();

      // finish back-pressure while the next command waits
      hold_ready = 1'b1;
      mk_exec(1, 1, 64'hFEED);
      run_cmd();
      mk_exec(2, 2, 64'hBEEF);
      fork
         begin
            repeat (20) @(negedge aclk);
            hold_ready = 1'b0;
         end
         run_cmd();
      join
      wait_idle();

      // reset during ARGS, then a fresh command
      mk_exec(4, 4, 64'hDEAD);
      send_cmd(3);
      rst = 1'b1;
      @(negedge aclk);
      rst = 1'b0;
      model_reset();
      check_reset_vals();
      mk_exec(2, 2, 64'hC0DE);
      run_cmd();
      wait_idle();

      // random mix
      for (int k = 0; k < 30; k++) begin
         kind = int'($urandom_range(0, 9));
         if (kind < 7)
            mk_exec(int'($urandom_range(0, 15)), int'($urandom_range(0, (kind == 0) ? 11 : MAX_ARGS)), {$urandom, $urandom});
         else if (kind < 9)
            mk_other(8'($urandom_range(2, 255)), int'($urandom_range(0, 3)));
         else
            mk_other(8'h01, 0);
         run_cmd();
      end
      wait_idle();
      check("start_count", 64'(seen_starts), 64'(exp_starts));
      check_errs();
      finish_run();
   end

endmodule
